// File: rtl/pix_pkg.sv
// Shared constants and FSM state type for the OLED pixel scan path.
package pix_pkg;
    localparam int OLED_W = 96;
    localparam int OLED_H = 64;

    typedef enum logic {
        TRACK  = 1'b0,
        RESYNC = 1'b1
    } state_t;
endpackage

// File: rtl/pix_resync_div.sv
// Iterative subtract-divisor divider. quot/rem carry the final result during the done cycle.
module pix_resync_div #(
    parameter int DIVISOR = 96,
    parameter int D_W     = 13,
    parameter int Q_W     = 7,
    parameter int R_W     = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [D_W-1:0] dividend,
    output logic           busy,
    output logic           done,
    output logic [Q_W-1:0] quot,
    output logic [R_W-1:0] rem
);
    localparam logic [D_W-1:0] DIV  = D_W'(DIVISOR);
    localparam logic [D_W-1:0] DIV2 = D_W'(2 * DIVISOR);

    logic [D_W-1:0] rem_q;
    logic [Q_W-1:0] quot_q;
    logic [D_W-1:0] rem_fin;
    logic [Q_W-1:0] quot_fin;
    logic           ge;

    // The step that brings the remainder below DIVISOR also finishes, saving a cycle.
    assign ge       = rem_q >= DIV;
    assign done     = busy && (rem_q < DIV2);
    assign rem_fin  = ge ? rem_q - DIV : rem_q;
    assign quot_fin = ge ? quot_q + Q_W'(1) : quot_q;
    assign rem      = rem_fin[R_W-1:0];
    assign quot     = quot_fin;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            rem_q  <= '0;
            quot_q <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            rem_q  <= dividend;
            quot_q <= '0;
        end else if (busy) begin
            rem_q  <= rem_fin;
            quot_q <= quot_fin;
            if (done) busy <= 1'b0;
        end
    end
endmodule

// File: rtl/pix_scan_xy.sv
// Pixel-index to (x,y) converter: incremental raster tracking with divider-based resync on jumps.
// state  | meaning
// TRACK  | following the raster, one pixel per strobe at 1-cycle latency
// RESYNC | divider running after an index jump; new strobes are dropped
module pix_scan_xy
    import pix_pkg::*;
#(
    parameter int WIDTH  = OLED_W,
    parameter int HEIGHT = OLED_H,
    parameter int IDX_W  = 13,
    parameter int X_W    = 8,
    parameter int Y_W    = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_valid,
    input  logic [IDX_W-1:0] pixel_index,
    input  logic             mirror_x,
    input  logic             mirror_y,
    output logic [X_W-1:0]   pos_x,
    output logic [Y_W-1:0]   pos_y,
    output logic             xy_valid,
    output logic             frame_start,
    output logic             line_end,
    output logic             frame_end,
    output logic             busy,
    output logic             err_range,
    output logic             err_overrun
);
    localparam logic [IDX_W-1:0] NPIX   = IDX_W'(WIDTH * HEIGHT);
    localparam logic [IDX_W-1:0] LAST   = IDX_W'(WIDTH * HEIGHT - 1);
    localparam logic [X_W-1:0]   X_LAST = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0]   Y_LAST = Y_W'(HEIGHT - 1);

    state_t           state, state_n;
    logic [IDX_W-1:0] exp_idx, idx_q, e_idx;
    logic [X_W-1:0]   x_q, e_x, div_rem;
    logic [Y_W-1:0]   y_q, e_y, div_quot;
    logic             mx_q, my_q, mx_n, my_n;
    logic             start_div, emit_trk, emit_rs, emit, err_rng, err_ovr;
    logic             div_done, first, last;

    pix_resync_div #(
        .DIVISOR (WIDTH),
        .D_W     (IDX_W),
        .Q_W     (Y_W),
        .R_W     (X_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_div),
        .dividend (pixel_index),
        .busy     (busy),
        .done     (div_done),
        .quot     (div_quot),
        .rem      (div_rem)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= TRACK;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        start_div = 1'b0;
        emit_trk  = 1'b0;
        emit_rs   = 1'b0;
        err_rng   = 1'b0;
        err_ovr   = 1'b0;
        case (state)
            TRACK: begin
                if (pix_valid) begin
                    if (pixel_index >= NPIX) begin
                        err_rng = 1'b1;
                    end else if (pixel_index == exp_idx) begin
                        emit_trk = 1'b1;
                    end else begin
                        start_div = 1'b1;
                        state_n   = RESYNC;
                    end
                end
            end
            RESYNC: begin
                if (pix_valid) err_ovr = 1'b1;
                if (div_done) begin
                    emit_rs = 1'b1;
                    state_n = TRACK;
                end
            end
            default: state_n = TRACK;
        endcase
    end

    // Mirror settings for a resynced index 0 were captured when its strobe arrived.
    assign emit  = emit_trk | emit_rs;
    assign e_idx = emit_trk ? pixel_index : idx_q;
    assign e_x   = emit_trk ? x_q : div_rem;
    assign e_y   = emit_trk ? y_q : div_quot;
    assign first = (e_idx == '0);
    assign last  = (e_idx == LAST);
    assign mx_n  = (emit_trk && first) ? mirror_x : mx_q;
    assign my_n  = (emit_trk && first) ? mirror_y : my_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exp_idx     <= '0;
            idx_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            mx_q        <= 1'b0;
            my_q        <= 1'b0;
            pos_x       <= '0;
            pos_y       <= '0;
            xy_valid    <= 1'b0;
            frame_start <= 1'b0;
            line_end    <= 1'b0;
            frame_end   <= 1'b0;
            err_range   <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            xy_valid    <= emit;
            frame_start <= emit & first;
            frame_end   <= emit & last;
            line_end    <= emit & (e_x == X_LAST);
            err_range   <= err_rng;
            err_overrun <= err_ovr;
            if (start_div) begin
                idx_q <= pixel_index;
                if (pixel_index == '0) begin
                    mx_q <= mirror_x;
                    my_q <= mirror_y;
                end
            end
            if (emit) begin
                mx_q    <= mx_n;
                my_q    <= my_n;
                pos_x   <= mx_n ? X_LAST - e_x : e_x;
                pos_y   <= my_n ? Y_LAST - e_y : e_y;
                exp_idx <= last ? '0 : e_idx + IDX_W'(1);
                if (e_x == X_LAST) begin
                    x_q <= '0;
                    y_q <= (e_y == Y_LAST) ? '0 : e_y + Y_W'(1);
                end else begin
                    x_q <= e_x + X_W'(1);
                    y_q <= e_y;
                end
            end
        end
    end
endmodule
